// File: rtl/infra_pkg.sv
// Shared types and constants for the infrastructure reset/monitor slice.
// State encoding is fixed so the monitor register bus can decode it.
package infra_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } rst_state_t;

  localparam int unsigned              LOSS_CNT_W   = 8;
  localparam logic [LOSS_CNT_W-1:0]    LOSS_CNT_MAX = 8'd255;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer for asynchronous level inputs.
// Deliberately unreset so the chain maps onto plain synchronizer cells.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/infra_reset_seq.sv
// Reset sequencer: qualifies PLL lock, holds system reset for a fixed time,
// and records loss-of-lock events as a sticky flag plus saturating counter.
module infra_reset_seq
  import infra_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 256,
  parameter int unsigned CNT_W              = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  soft_reset,
  input  logic                  clear_status,
  output logic                  rst_out,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

  logic                  lock_s;
  rst_state_t            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  lock_lost_nxt;
  logic [LOSS_CNT_W-1:0] loss_cnt_nxt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      lock_lost       <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      lock_lost       <= lock_lost_nxt;
      lock_loss_count <= loss_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    // Clear is folded in first so a loss in the same cycle lands on top of it.
    lock_lost_nxt = clear_status ? 1'b0 : lock_lost;
    loss_cnt_nxt  = clear_status ? '0   : lock_loss_count;

    unique case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt     = WAIT_LOCK;
          lock_lost_nxt = 1'b1;
          if (loss_cnt_nxt != LOSS_CNT_MAX)
            loss_cnt_nxt = loss_cnt_nxt + LOSS_CNT_W'(1);
        end else if (soft_reset) begin
          state_nxt = HOLD;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign rst_out = (state != RUN);
  assign ready   = (state == RUN);

endmodule

// File: tb/tb_infra_reset_seq.sv
// Scoreboard bench for infra_reset_seq: a timestamp-based reference model
// predicts outputs per edge, a negedge monitor pops and compares.
module tb_infra_reset_seq;

  localparam int unsigned L = 8;
  localparam int unsigned H = 4;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       soft_reset;
  logic       clear_status;
  logic       rst_out;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lock_loss_count;

  infra_reset_seq #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (L),
    .RESET_HOLD_CYCLES  (H),
    .CNT_W              (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pll_lock        (pll_lock),
    .soft_reset      (soft_reset),
    .clear_status    (clear_status),
    .rst_out         (rst_out),
    .ready           (ready),
    .lock_lost       (lock_lost),
    .lock_loss_count (lock_loss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       lost;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: lock history as a 2-deep delay line, release time as a
  // timestamp; mode 0 = no lock, 1 = qualifying, 2 = released.
  int   now        = 0;
  int   mode       = 0;
  int   release_at = 0;
  bit   m_lost     = 0;
  int   m_cnt      = 0;
  bit   pipe0      = 0;
  bit   pipe1      = 0;

  always @(posedge clk) begin
    bit   ls;
    exp_t e;
    now++;
    ls    = pipe1;
    pipe1 = pipe0;
    pipe0 = pll_lock;
    if (reset) begin
      mode   = 0;
      m_lost = 0;
      m_cnt  = 0;
    end else begin
      if (clear_status) begin
        m_lost = 0;
        m_cnt  = 0;
      end
      if (mode == 0) begin
        if (ls) begin
          mode       = 1;
          release_at = now + L + H;
        end
      end else if (mode == 1) begin
        if (!ls) mode = 0;
        else if (now == release_at) mode = 2;
      end else begin
        if (!ls) begin
          mode   = 0;
          m_lost = 1;
          if (m_cnt < 255) m_cnt++;
        end else if (soft_reset) begin
          mode       = 1;
          release_at = now + H;
        end
      end
    end
    e.rst  = (mode != 2);
    e.lost = m_lost;
    e.cnt  = 8'(m_cnt);
    exp_q.push_back(e);
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rst_out",         int'(rst_out),         int'(e.rst));
      check("ready",           int'(ready),           int'(!e.rst));
      check("lock_lost",       int'(lock_lost),       int'(e.lost));
      check("lock_loss_count", int'(lock_loss_count), int'(e.cnt));
    end
  end

  task automatic cyc(input logic pl, input logic sr, input logic cs, input logic rs);
    pll_lock     = pl;
    soft_reset   = sr;
    clear_status = cs;
    reset        = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n, input logic pl);
    for (int i = 0; i < n; i++) cyc(pl, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    pll_lock     = 1'b0;
    soft_reset   = 1'b0;
    clear_status = 1'b0;
    reset        = 1'b1;

    // Power-up reset with no lock
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    run_n(3, 1'b0);

    // Clean lock, then stay released
    run_n(25, 1'b1);

    // Soft reset in RUN: exactly H cycles of reset
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    run_n(10, 1'b1);

    // Soft reset, then a second pulse while in HOLD (no extension)
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    run_n(2, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    run_n(10, 1'b1);

    // Lock loss for 3 cycles, relock through full sequence
    run_n(3, 1'b0);
    run_n(20, 1'b1);

    // Glitchy lock from a fresh reset
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    run_n(5, 1'b1);
    run_n(1, 1'b0);
    run_n(20, 1'b1);

    // clear_status coincident with the lock-loss edge
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    run_n(20, 1'b1);

    // soft_reset coincident with the lock-loss edge
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    run_n(20, 1'b1);

    // reset asserted while in HOLD
    run_n(3, 1'b0);
    run_n(13, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    run_n(20, 1'b1);

    // 300 losses: counter must saturate
    for (int k = 0; k < 300; k++) begin
      run_n(3, 1'b0);
      run_n(16, 1'b1);
    end

    // Randomised mix of all inputs
    for (int i = 0; i < 4000; i++) begin
      logic pl, sr, cs, rs;
      pl = ($urandom_range(0, 19) != 0);
      sr = ($urandom_range(0, 24) == 0);
      cs = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 299) == 0);
      cyc(pl, sr, cs, rs);
    end

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
